// File: rtl/fir_coeff_ctrl.sv
// fir_coeff_ctrl: coefficient sequencer for the FIR datapath.
// Writes go into a shadow bank. The shadow bank is copied atomically into the
// active bank in one SWAP cycle. After start or reload, out_valid stays low
// until the tap pipeline has flushed.
// Optional feature macro: FIR_COEFF_READBACK_EN adds a registered readback
// port for the active bank (rb_addr / rb_data).
module fir_coeff_ctrl #(
    parameter int BITWIDTH = 16,
    parameter int N        = 16,
    parameter int P        = 4,
    // One extra address bit when N is a power of two, so out-of-range
    // writes (addr >= N) can be expressed and flagged.
    localparam int ADDRW   = $clog2(N + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [ADDRW-1:0]      cfg_addr,
    input  logic [BITWIDTH-1:0]   cfg_data,
    input  logic                  cfg_last,
    output logic                  cfg_err,
    input  logic                  run,
    output logic [N*BITWIDTH-1:0] coeffs,
    output logic                  fir_enable,
    output logic                  out_valid,
    output logic                  swap_done,
    output logic                  busy
`ifdef FIR_COEFF_READBACK_EN
    ,
    input  logic [ADDRW-1:0]      rb_addr,
    output logic [BITWIDTH-1:0]   rb_data
`endif
);

    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam int CNTW = $clog2(N + P);
    localparam logic [CNTW-1:0]  FLUSH_LEN = CNTW'(N + P - 1);
    localparam logic [ADDRW-1:0] N_A       = ADDRW'(N);

    typedef enum logic [1:0] {IDLE, SWAP, FLUSH, RUN} state_e;

    state_e              state_q, state_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [BITWIDTH-1:0] shadow_q [N];
    logic [BITWIDTH-1:0] active_q [N];
    logic                swap_pending_q;
    logic                swap_done_q;
    logic                cfg_err_q;
    logic                wr_fire;
    logic                wr_oob;
    logic                swap_req;

    assign cfg_ready = !swap_pending_q;
    assign wr_fire   = cfg_valid & cfg_ready;
    assign wr_oob    = cfg_addr >= N_A;
    // A final write takes effect for the FSM in the same cycle it is accepted,
    // so a swap always wins over a run request arriving alongside it.
    assign swap_req  = swap_pending_q | (wr_fire & cfg_last);

    // Shadow bank writes, sticky out-of-range error and swap request flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                shadow_q[i] <= '0;
            end
            cfg_err_q      <= 1'b0;
            swap_pending_q <= 1'b0;
        end else begin
            if (wr_fire) begin
                if (wr_oob) begin
                    cfg_err_q <= 1'b1;
                end else begin
                    shadow_q[cfg_addr[IDXW-1:0]] <= cfg_data;
                end
            end
            if (wr_fire && cfg_last) begin
                swap_pending_q <= 1'b1;
            end else if (state_q == SWAP) begin
                swap_pending_q <= 1'b0;
            end
        end
    end

    // State, flush counter, active bank copy and swap_done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            swap_done_q <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                active_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            swap_done_q <= (state_q == SWAP);
            if (state_q == SWAP) begin
                for (int unsigned i = 0; i < N; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
        end
    end

    // Next-state logic; swap requests take priority over run in every state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (swap_req) begin
                    state_d = SWAP;
                end else if (run) begin
                    state_d = FLUSH;
                    cnt_d   = FLUSH_LEN;
                end
            end
            SWAP: begin
                if (run) begin
                    state_d = FLUSH;
                    cnt_d   = FLUSH_LEN;
                end else begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (swap_req) begin
                    state_d = SWAP;
                end else if (!run) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                    if (cnt_q == CNTW'(1)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (swap_req) begin
                    state_d = SWAP;
                end else if (!run) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fir_enable = (state_q == FLUSH) || (state_q == RUN);
    assign out_valid  = (state_q == RUN);
    assign swap_done  = swap_done_q;
    assign cfg_err    = cfg_err_q;
    assign busy       = (state_q != IDLE) || swap_pending_q;

    for (genvar g = 0; g < N; g++) begin : g_coeffs
        assign coeffs[g*BITWIDTH +: BITWIDTH] = active_q[g];
    end

`ifdef FIR_COEFF_READBACK_EN
    logic [BITWIDTH-1:0] rb_data_q;

    // Registered readback of the active bank; out-of-range addresses read 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rb_data_q <= '0;
        end else if (rb_addr < N_A) begin
            rb_data_q <= active_q[rb_addr[IDXW-1:0]];
        end else begin
            rb_data_q <= '0;
        end
    end

    assign rb_data = rb_data_q;
`endif

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Directed testbench for fir_coeff_ctrl (default parameters).
// Define FIR_COEFF_READBACK_EN to also exercise the readback port.
module tb_fir_coeff_ctrl;

    localparam int BW = 16;
    localparam int N  = 16;
    localparam int P  = 4;
    localparam int AW = 5;
    localparam int FL = N + P - 1;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [AW-1:0]   cfg_addr;
    logic [BW-1:0]   cfg_data;
    logic            cfg_last;
    logic            cfg_err;
    logic            run;
    logic [N*BW-1:0] coeffs;
    logic            fir_enable;
    logic            out_valid;
    logic            swap_done;
    logic            busy;
`ifdef FIR_COEFF_READBACK_EN
    logic [AW-1:0]   rb_addr;
    logic [BW-1:0]   rb_data;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    fir_coeff_ctrl #(.BITWIDTH(BW), .N(N), .P(P)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_last   (cfg_last),
        .cfg_err    (cfg_err),
        .run        (run),
        .coeffs     (coeffs),
        .fir_enable (fir_enable),
        .out_valid  (out_valid),
        .swap_done  (swap_done),
        .busy       (busy)
`ifdef FIR_COEFF_READBACK_EN
        ,
        .rb_addr    (rb_addr),
        .rb_data    (rb_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] tap(input int i);
        return 32'(coeffs[i*BW +: BW]);
    endfunction

    // Present one write and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic write_coef(input logic [AW-1:0] a, input logic [BW-1:0] d, input logic last);
        int w;
        w = 0;
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        cfg_last  = last;
        while (!cfg_ready && w < 50) begin
            tick;
            w++;
        end
        if (!cfg_ready) check_eq("wr_ready_timeout", 32'(cfg_ready), 32'd1);
        tick;
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    // Count enabled cycles until out_valid rises, starting in the current cycle.
    task automatic measure_flush(input string tag);
        int n;
        int guard;
        n = 0;
        guard = 0;
        while (!out_valid && guard < 100) begin
            if (fir_enable) n++;
            tick;
            guard++;
        end
        check_eq(tag, 32'(n), 32'(FL));
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_en"},    32'(fir_enable), 32'd0);
        check_eq({tag, "_ov"},    32'(out_valid),  32'd0);
        check_eq({tag, "_sd"},    32'(swap_done),  32'd0);
        check_eq({tag, "_err"},   32'(cfg_err),    32'd0);
        check_eq({tag, "_busy"},  32'(busy),       32'd0);
        check_eq({tag, "_rdy"},   32'(cfg_ready),  32'd1);
        check_eq({tag, "_tap0"},  tap(0),          32'd0);
        check_eq({tag, "_tap15"}, tap(15),         32'd0);
`ifdef FIR_COEFF_READBACK_EN
        check_eq({tag, "_rb"},    32'(rb_data),    32'd0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        cfg_valid = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        cfg_last  = 1'b0;
        run       = 1'b0;
`ifdef FIR_COEFF_READBACK_EN
        rb_addr   = '0;
`endif
        repeat (3) tick;
        check_idle_outputs("rst");
        @(negedge clk);
        reset_n = 1'b1;
        tick;
        check_idle_outputs("post_rst");

        // Test 1: load tap i = i, final write coincides with run rising.
        for (int i = 0; i < N - 1; i++) write_coef(AW'(i), BW'(i), 1'b0);
        check_eq("t1_shadow_hidden", tap(7), 32'd0);
        check_eq("t1_busy_idle", 32'(busy), 32'd0);
        run = 1'b1;
        write_coef(AW'(15), BW'(15), 1'b1);
        check_eq("t1_swap_en", 32'(fir_enable), 32'd0);
        check_eq("t1_swap_ov", 32'(out_valid), 32'd0);
        check_eq("t1_swap_rdy", 32'(cfg_ready), 32'd0);
        check_eq("t1_swap_busy", 32'(busy), 32'd1);
        check_eq("t1_swap_tap15", tap(15), 32'd0);
        tick;
        check_eq("t1_swap_done", 32'(swap_done), 32'd1);
        check_eq("t1_flush_en", 32'(fir_enable), 32'd1);
        check_eq("t1_rdy_after", 32'(cfg_ready), 32'd1);
        for (int i = 0; i < N; i++) check_eq($sformatf("t1_tap%0d", i), tap(i), 32'(i));
        measure_flush("t1_flush_len");
        check_eq("t1_sd_low", 32'(swap_done), 32'd0);

`ifdef FIR_COEFF_READBACK_EN
        // Test 6: registered readback of the active bank.
        rb_addr = AW'(5);
        tick;
        check_eq("t6_rb5", 32'(rb_data), 32'd5);
        rb_addr = AW'(15);
        tick;
        check_eq("t6_rb15", 32'(rb_data), 32'd15);
        rb_addr = AW'(16);
        tick;
        check_eq("t6_rb_oob", 32'(rb_data), 32'd0);
`endif

        // Test 2: reload all taps to 1 while running.
        for (int i = 0; i < N - 1; i++) write_coef(AW'(i), BW'(1), 1'b0);
        check_eq("t2_still_valid", 32'(out_valid), 32'd1);
        check_eq("t2_tap3_old", tap(3), 32'd3);
        write_coef(AW'(15), BW'(1), 1'b1);
        check_eq("t2_swap_ov", 32'(out_valid), 32'd0);
        check_eq("t2_swap_en", 32'(fir_enable), 32'd0);
        check_eq("t2_swap_rdy", 32'(cfg_ready), 32'd0);
        check_eq("t2_swap_tap5_old", tap(5), 32'd5);
        tick;
        check_eq("t2_swap_done", 32'(swap_done), 32'd1);
        for (int i = 0; i < N; i++) check_eq($sformatf("t2_tap%0d", i), tap(i), 32'd1);
        measure_flush("t2_flush_len");

        // Test 3: out-of-range write is dropped and flags a sticky error.
        write_coef(AW'(16), 16'h7FFF, 1'b0);
        check_eq("t3_err", 32'(cfg_err), 32'd1);
        check_eq("t3_tap0", tap(0), 32'd1);
        check_eq("t3_ov", 32'(out_valid), 32'd1);
        write_coef(AW'(1), BW'(1), 1'b1);
        tick;
        check_eq("t3_swap_done", 32'(swap_done), 32'd1);
        for (int i = 0; i < N; i++) check_eq($sformatf("t3_tap%0d", i), tap(i), 32'd1);
        check_eq("t3_err_held", 32'(cfg_err), 32'd1);
        measure_flush("t3_flush_len");

        // Test 4: drop run for one cycle at flush count 5, then full re-flush.
        run = 1'b0;
        tick;
        check_eq("t4_idle_en", 32'(fir_enable), 32'd0);
        check_eq("t4_idle_busy", 32'(busy), 32'd0);
        run = 1'b1;
        tick;
        repeat (14) tick;
        check_eq("t4_mid_en", 32'(fir_enable), 32'd1);
        check_eq("t4_mid_ov", 32'(out_valid), 32'd0);
        run = 1'b0;
        tick;
        check_eq("t4_abort_en", 32'(fir_enable), 32'd0);
        check_eq("t4_abort_ov", 32'(out_valid), 32'd0);
        run = 1'b1;
        tick;
        measure_flush("t4_flush_restart");
        check_eq("t4_err_held", 32'(cfg_err), 32'd1);

        // Test 5: asynchronous reset with a swap pending.
        write_coef(AW'(2), 16'h1234, 1'b1);
        check_eq("t5_pending_busy", 32'(busy), 32'd1);
        check_eq("t5_pending_rdy", 32'(cfg_ready), 32'd0);
        reset_n = 1'b0;
        run     = 1'b0;
        #1;
        check_idle_outputs("t5_async");
        check_eq("t5_tap2", tap(2), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick;
        tick;
        check_eq("t5_no_swap", 32'(swap_done), 32'd0);
        check_eq("t5_tap2_after", tap(2), 32'd0);
        check_eq("t5_busy_after", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
